irq_controller_8: RTL and testbench

8-channel interrupt request front end that captures raw interrupt lines, holds per-channel pending state, applies a mask, and selects the highest-priority request using the 8-to-3 priority encoder. It presents one request at a time to the consumer (CPU/sequencer) through a request/acknowledge handshake, then clears the serviced pending bit. It sits directly upstream of the priority encoder and is the block that owns it.

---
 rtl/irq_controller_8_pkg.sv | 20 ++
 rtl/irq_controller_8_priority_encoder_8to3.sv | 27 ++
 rtl/irq_controller_8.sv | 112 +++++++++++
 tb/tb_irq_controller_8.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_8_pkg.sv
// Shared definitions for the 8-channel interrupt controller.
package irq_controller_8_pkg;

  localparam int IRQ_CHANNELS = 8;
  localparam int IRQ_ID_W     = 3;

  // Handshake FSM states: IDLE looks for a request, REQ holds one until ack.
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_e;

  // One-hot vector selecting the channel with the given index.
  function automatic logic [IRQ_CHANNELS-1:0] id_to_onehot(input logic [IRQ_ID_W-1:0] id);
    logic [IRQ_CHANNELS-1:0] vec;
    vec = 8'h01 << id;
    return vec;
  endfunction

endpackage

// File: rtl/irq_controller_8_priority_encoder_8to3.sv
// 8-to-3 priority encoder: bit 7 wins, valid when any bit is set.
module priority_encoder_8to3
  import irq_controller_8_pkg::*;
(
  input  logic [IRQ_CHANNELS-1:0] in,
  output logic [IRQ_ID_W-1:0]     out,
  output logic                    valid
);

  // Highest set bit selects the output index.
  always_comb begin
    out   = 3'd0;
    valid = |in;
    casez (in)
      8'b1???????: out = 3'd7;
      8'b01??????: out = 3'd6;
      8'b001?????: out = 3'd5;
      8'b0001????: out = 3'd4;
      8'b00001???: out = 3'd3;
      8'b000001??: out = 3'd2;
      8'b0000001?: out = 3'd1;
      8'b00000001: out = 3'd0;
      default:     out = 3'd0;
    endcase
  end

endmodule

// File: rtl/irq_controller_8.sv
// 8-channel interrupt front end: edge/level capture, pending state, mask,
// priority selection and a req/ack handshake that presents one id at a time.
module irq_controller_8
  import irq_controller_8_pkg::*;
#(
  parameter logic [IRQ_CHANNELS-1:0] EDGE_MODE  = 8'hFF,
  parameter logic [IRQ_CHANNELS-1:0] MASK_RESET = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IRQ_CHANNELS-1:0] irq_in,
  input  logic                    mask_we,
  input  logic [IRQ_CHANNELS-1:0] mask_wdata,
  input  logic                    irq_ack,
  output logic                    irq_req,
  output logic [IRQ_ID_W-1:0]     irq_id,
  output logic [IRQ_CHANNELS-1:0] pending,
  output logic [IRQ_CHANNELS-1:0] mask
);

  logic [IRQ_CHANNELS-1:0] in_q_r;
  logic [IRQ_CHANNELS-1:0] pend_edge_r;
  logic [IRQ_CHANNELS-1:0] mask_r;
  irq_state_e              state_r;
  logic [IRQ_ID_W-1:0]     id_r;
  logic                    req_r;

  logic [IRQ_CHANNELS-1:0] rise_s;
  logic [IRQ_CHANNELS-1:0] clr_s;
  logic [IRQ_CHANNELS-1:0] pend_edge_next_s;
  logic [IRQ_CHANNELS-1:0] pending_s;
  logic [IRQ_CHANNELS-1:0] eligible_s;
  logic [IRQ_ID_W-1:0]     enc_out_s;
  logic                    enc_valid_s;
  irq_state_e              state_next_s;
  logic [IRQ_ID_W-1:0]     id_next_s;

  // Edge channels keep a latched bit; level channels mirror the registered input.
  assign rise_s     = irq_in & ~in_q_r;
  assign pending_s  = (pend_edge_r & EDGE_MODE) | (in_q_r & ~EDGE_MODE);
  assign eligible_s = pending_s & ~mask_r;

  priority_encoder_8to3 u_enc (
    .in    (eligible_s),
    .out   (enc_out_s),
    .valid (enc_valid_s)
  );

  // Clear vector for the serviced channel; acks outside REQ do nothing.
  always_comb begin
    clr_s = 8'h00;
    if ((state_r == REQ) && irq_ack) begin
      clr_s = id_to_onehot(id_r);
    end else begin
      clr_s = 8'h00;
    end
  end

  // A new rise is OR-ed in after the clear so it survives a same-cycle ack.
  assign pend_edge_next_s = ((pend_edge_r & ~clr_s) | rise_s) & EDGE_MODE;

  // Handshake next-state: grant latches the encoder id, ack releases it.
  always_comb begin
    state_next_s = state_r;
    id_next_s    = id_r;
    case (state_r)
      IDLE: begin
        if (enc_valid_s) begin
          state_next_s = REQ;
          id_next_s    = enc_out_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = REQ;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, capture and mask registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q_r      <= 8'h00;
      pend_edge_r <= 8'h00;
      mask_r      <= MASK_RESET;
      state_r     <= IDLE;
      id_r        <= 3'd0;
      req_r       <= 1'b0;
    end else begin
      in_q_r      <= irq_in;
      pend_edge_r <= pend_edge_next_s;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end
      state_r     <= state_next_s;
      id_r        <= id_next_s;
      req_r       <= (state_next_s == REQ);
    end
  end

  assign irq_req = req_r;
  assign irq_id  = id_r;
  assign pending = pending_s;
  assign mask    = mask_r;

endmodule

// File: tb/tb_irq_controller_8.sv
// Self-checking bench for irq_controller_8: one all-edge instance and one
// instance with channel 0 level-triggered; expected grant ids are queued.
module tb_irq_controller_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in, mask_wdata, pending, mask;
  logic       mask_we, irq_ack, irq_req;
  logic [2:0] irq_id;
  logic [7:0] l_irq_in, l_mask_wdata, l_pending, l_mask;
  logic       l_mask_we, l_irq_ack, l_irq_req;
  logic [2:0] l_irq_id;

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];
  logic       sel_lvl;

  always #5 clk = ~clk;

  irq_controller_8 dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .irq_ack(irq_ack), .irq_req(irq_req),
    .irq_id(irq_id), .pending(pending), .mask(mask)
  );

  irq_controller_8 #(.EDGE_MODE(8'hFE), .MASK_RESET(8'h00)) dut_lvl (
    .clk(clk), .rst(rst), .irq_in(l_irq_in), .mask_we(l_mask_we),
    .mask_wdata(l_mask_wdata), .irq_ack(l_irq_ack), .irq_req(l_irq_req),
    .irq_id(l_irq_id), .pending(l_pending), .mask(l_mask)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant on the selected instance, then pop and compare.
  task automatic expect_grant(input string tag, input int exp_lat);
    int         n;
    logic       r;
    logic [2:0] id;
    logic [2:0] e;
    n = 1;
    r = sel_lvl ? l_irq_req : irq_req;
    while (!r && n < 20) begin
      step();
      n++;
      r = sel_lvl ? l_irq_req : irq_req;
    end
    id = sel_lvl ? l_irq_id : irq_id;
    check_eq({tag, "_req"}, r, 1);
    check_eq({tag, "_lat"}, n, exp_lat);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_id"}, id, e);
    end else begin
      check_eq({tag, "_queue"}, 0, 1);
    end
  endtask

  task automatic do_ack();
    if (sel_lvl) l_irq_ack = 1'b1; else irq_ack = 1'b1;
    step();
    l_irq_ack = 1'b0;
    irq_ack   = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_we = 1'b1; mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    step();
    irq_in = 8'h00;
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; irq_ack = 1'b0;
    l_irq_in = 8'h00; l_mask_we = 1'b0; l_mask_wdata = 8'h00; l_irq_ack = 1'b0;
    sel_lvl = 1'b0;
    step(); step();
    check_eq("rst_req", irq_req, 0);
    check_eq("rst_id", irq_id, 0);
    check_eq("rst_pending", pending, 8'h00);
    check_eq("rst_mask", mask, 8'h00);
    rst = 1'b0;
    step();

    // Single edge pulse on channel 2.
    exp_q.push_back(3'd2);
    pulse(8'h04);
    check_eq("t1_pending", pending, 8'h04);
    expect_grant("t1", 2);
    do_ack();
    check_eq("t1_ack_req", irq_req, 0);
    check_eq("t1_ack_pending", pending, 8'h00);

    // Two channels together: 7 first, then 0 after one idle cycle.
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    pulse(8'h81);
    expect_grant("t2a", 2);
    do_ack();
    check_eq("t2_pending", pending, 8'h01);
    expect_grant("t2b", 2);
    do_ack();

    // Ack while IDLE must not clear the pending (masked) channel 0.
    write_mask(8'h01);
    pulse(8'h01);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_eq("idle_ack_pending", pending, 8'h01);
    check_eq("idle_ack_req", irq_req, 0);
    exp_q.push_back(3'd0);
    write_mask(8'h00);
    expect_grant("idle_ack_unmask", 2);
    do_ack();

    // Mask channel 7: only 0 is granted, 7 stays pending until unmasked.
    write_mask(8'h80);
    check_eq("t3_mask", mask, 8'h80);
    exp_q.push_back(3'd0);
    pulse(8'h81);
    expect_grant("t3a", 2);
    do_ack();
    check_eq("t3_pending", pending, 8'h80);
    step(); step();
    check_eq("t3_masked_req", irq_req, 0);
    exp_q.push_back(3'd7);
    write_mask(8'h00);
    expect_grant("t3b", 2);
    do_ack();
    check_eq("t3_clear", pending, 8'h00);

    // Mask write coinciding with a grant uses the old mask.
    exp_q.push_back(3'd4);
    pulse(8'h10);
    write_mask(8'h10);
    expect_grant("oldmask", 1);
    do_ack();
    write_mask(8'h00);

    // New rise on the acked channel in the ack cycle keeps its bit.
    exp_q.push_back(3'd5);
    pulse(8'h20);
    expect_grant("setwin_a", 2);
    irq_in = 8'h20; irq_ack = 1'b1;
    step();
    irq_in = 8'h00; irq_ack = 1'b0;
    check_eq("setwin_pending", pending, 8'h20);
    exp_q.push_back(3'd5);
    expect_grant("setwin_b", 2);
    do_ack();

    // Request is never retracted by masking or a higher-priority arrival.
    exp_q.push_back(3'd3);
    pulse(8'h08);
    expect_grant("t5a", 2);
    irq_in = 8'h40; mask_we = 1'b1; mask_wdata = 8'h08;
    step();
    irq_in = 8'h00; mask_we = 1'b0;
    step();
    check_eq("t5_hold_req", irq_req, 1);
    check_eq("t5_hold_id", irq_id, 3);
    exp_q.push_back(3'd6);
    do_ack();
    check_eq("t5_pending", pending, 8'h40);
    expect_grant("t5b", 2);
    do_ack();
    write_mask(8'h00);

    // All channels pending: grants in order 7 down to 0.
    for (int k = 7; k >= 0; k--) exp_q.push_back(3'(k));
    pulse(8'hFF);
    for (int k = 7; k >= 0; k--) begin
      expect_grant("all8", 2);
      do_ack();
    end
    check_eq("all8_pending", pending, 8'h00);

    // Level channel 0: re-granted after each ack while held high.
    sel_lvl = 1'b1;
    l_irq_in = 8'h01;
    exp_q.push_back(3'd0);
    step();
    expect_grant("lvl_first", 2);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(3'd0);
      do_ack();
      check_eq("lvl_ack_req", l_irq_req, 0);
      check_eq("lvl_pending", l_pending, 8'h01);
      expect_grant("lvl_regrant", 2);
    end
    l_irq_in = 8'h00;
    step();
    check_eq("lvl_drop_req", l_irq_req, 1);
    check_eq("lvl_drop_pending", l_pending, 8'h00);
    do_ack();
    step(); step();
    check_eq("lvl_done_req", l_irq_req, 0);
    sel_lvl = 1'b0;

    // Reset during REQ with everything pending.
    exp_q.push_back(3'd7);
    pulse(8'hFF);
    expect_grant("rstreq", 2);
    write_mask(8'h0F);
    check_eq("rstreq_mask", mask, 8'h0F);
    check_eq("rstreq_pending", pending, 8'hFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstreq_req", irq_req, 0);
    check_eq("rstreq_pend0", pending, 8'h00);
    check_eq("rstreq_mask0", mask, 8'h00);
    check_eq("rstreq_id0", irq_id, 0);
    step(); step();
    check_eq("rstreq_stay_idle", irq_req, 0);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
